// File: rtl/leg_imem_loader.sv
// leg_imem_loader
//   Instruction memory with a byte-stream program loader in front of a small
//   CPU. A load request fills the first i_load_len bytes of memory. The CPU
//   may fetch from memory only after a load completes, and only until it is
//   halted or a new load begins.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst          asynchronous active-high reset
//   i_load_start   one-cycle load request, i_load_len sampled with it
//   i_load_len     byte count, legal 1..DEPTH
//   i_byte_valid   loader stream valid
//   i_byte         loader stream data
//   o_byte_ready   high exactly while loading
//   i_halt         one-cycle pulse that stops the CPU (RUN -> IDLE)
//   i_fetch_req    CPU fetch request
//   i_fetch_addr   CPU fetch address
//   o_fetch_valid  fetch data valid, one cycle after a serviced request
//   o_fetch_data   fetched byte, holds when no request is serviced
//   o_cpu_run      CPU permitted to fetch/execute
//   o_load_done    one-cycle pulse when the last byte is written
//   o_err          one-cycle pulse for a load request with an illegal length
module leg_imem_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic              i_byte_valid,
    input  logic [DATA_W-1:0] i_byte,
    output logic              o_byte_ready,
    input  logic              i_halt,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_fetch_valid,
    output logic [DATA_W-1:0] o_fetch_data,
    output logic              o_cpu_run,
    output logic              o_load_done,
    output logic              o_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic [ADDR_W:0]     cnt_reg;
    logic [DATA_W-1:0]   mem_reg [DEPTH];

    logic                byte_ready_reg;
    logic                cpu_run_reg;
    logic                load_done_reg;
    logic                err_reg;
    logic                fetch_valid_reg;
    logic [DATA_W-1:0]   fetch_data_reg;

    logic                len_legal;
    logic                wr_en;

    assign len_legal = (i_load_len != '0) && (i_load_len <= DEPTH_LEN);
    // byte_ready_reg is high exactly in LOAD, so this is the valid/ready handshake.
    assign wr_en     = byte_ready_reg && i_byte_valid;

    // Memory lives in flops so the whole array can be cleared by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[ptr_reg] <= i_byte;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            cnt_reg        <= '0;
            byte_ready_reg <= 1'b0;
            cpu_run_reg    <= 1'b0;
            load_done_reg  <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            load_done_reg <= 1'b0;
            err_reg       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_load_start) begin
                        if (len_legal) begin
                            state_reg      <= ST_LOAD;
                            ptr_reg        <= '0;
                            cnt_reg        <= i_load_len;
                            byte_ready_reg <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // New load requests are ignored until this one finishes.
                    if (wr_en) begin
                        ptr_reg <= ptr_reg + 1'b1;
                        cnt_reg <= cnt_reg - 1'b1;
                        if (cnt_reg == (ADDR_W + 1)'(1)) begin
                            // Pointer may wrap after a full-depth load, but no
                            // further write can happen outside LOAD.
                            state_reg      <= ST_RUN;
                            byte_ready_reg <= 1'b0;
                            cpu_run_reg    <= 1'b1;
                            load_done_reg  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // A load request (legal or not) takes priority over halt.
                    if (i_load_start) begin
                        if (len_legal) begin
                            state_reg      <= ST_LOAD;
                            ptr_reg        <= '0;
                            cnt_reg        <= i_load_len;
                            byte_ready_reg <= 1'b1;
                            cpu_run_reg    <= 1'b0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end else if (i_halt) begin
                        state_reg   <= ST_IDLE;
                        cpu_run_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    byte_ready_reg <= 1'b0;
                    cpu_run_reg    <= 1'b0;
                end
            endcase
        end
    end

    // Fetch port: one-cycle latency, data holds when nothing is serviced.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_valid_reg <= 1'b0;
            fetch_data_reg  <= '0;
        end else begin
            fetch_valid_reg <= i_fetch_req && cpu_run_reg;
            if (i_fetch_req && cpu_run_reg) begin
                fetch_data_reg <= mem_reg[i_fetch_addr];
            end
        end
    end

    assign o_byte_ready  = byte_ready_reg;
    assign o_cpu_run     = cpu_run_reg;
    assign o_load_done   = load_done_reg;
    assign o_err         = err_reg;
    assign o_fetch_valid = fetch_valid_reg;
    assign o_fetch_data  = fetch_data_reg;

endmodule

// File: doc/leg_imem_loader.md
LEG_IMEM_LOADER -- requirements
Module: leg_imem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, instruction byte width.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W (16).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_load_start, input, 1, one-cycle pulse requesting a program load.
REQ-006 SHALL have port i_load_len, input, ADDR_W+1, byte count for the load, sampled with i_load_start; legal range 1..DEPTH.
REQ-007 SHALL have port i_byte_valid, input, 1, loader byte stream valid.
REQ-008 SHALL have port i_byte, input, DATA_W, loader byte stream data.
REQ-009 SHALL have port o_byte_ready, output, 1, loader accepts a byte this cycle.
REQ-010 SHALL have port i_halt, input, 1, one-cycle pulse stopping CPU execution.
REQ-011 SHALL have port i_fetch_req, input, 1, CPU fetch request.
REQ-012 SHALL have port i_fetch_addr, input, ADDR_W, CPU fetch address (PC).
REQ-013 SHALL have port o_fetch_valid, output, 1, fetch data valid.
REQ-014 SHALL have port o_fetch_data, output, DATA_W, fetched instruction byte.
REQ-015 SHALL have port o_cpu_run, output, 1, CPU permitted to fetch/execute.
REQ-016 SHALL have port o_load_done, output, 1, one-cycle pulse on load completion.
REQ-017 SHALL have port o_err, output, 1, one-cycle pulse on illegal load length.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN; all outputs registered.
REQ-019 SHALL hold a DEPTH x DATA_W instruction memory in flops; 0x00 decodes as NOP in the CPU.
REQ-020 IDLE: i_load_start with i_load_len in 1..DEPTH SHALL enter LOAD next edge, write pointer = 0, remaining count = i_load_len.
REQ-021 i_load_start with i_load_len = 0 or > DEPTH SHALL pulse o_err for exactly one cycle; state unchanged; no write.
REQ-022 o_byte_ready SHALL be 1 exactly while state = LOAD.
REQ-023 Transfer SHALL occur only on i_byte_valid && o_byte_ready: mem[ptr] <= i_byte, ptr++; no transfer = no change.
REQ-024 On the transfer of the final byte SHALL enter RUN next edge, pulse o_load_done one cycle, o_cpu_run = 1, o_byte_ready = 0, all on that same edge.
REQ-025 Locations at or beyond i_load_len SHALL retain their previous contents.
REQ-026 Pointer SHALL be ADDR_W bits; a DEPTH-byte load writes addresses 0..DEPTH-1 exactly once, never wraps to rewrite 0.
REQ-027 i_load_start during LOAD SHALL be ignored.
REQ-028 RUN: i_load_start (legal length) SHALL enter LOAD, deasserting o_cpu_run on the same edge; illegal length SHALL pulse o_err and stay in RUN.
REQ-029 RUN: i_halt SHALL enter IDLE, o_cpu_run = 0 next edge; ignored in IDLE/LOAD; i_load_start wins over simultaneous i_halt.
REQ-030 Fetch: i_fetch_req while o_cpu_run = 1 SHALL yield o_fetch_valid = 1 and o_fetch_data = mem[i_fetch_addr] one cycle later (latency 1, back-to-back each cycle).
REQ-031 i_fetch_req while o_cpu_run = 0 SHALL be ignored: o_fetch_valid = 0, o_fetch_data holds.
REQ-032 o_fetch_valid SHALL be 0 in any cycle not following a serviced request.

Reset
REQ-033 i_rst SHALL asynchronously force state IDLE, pointer/count 0, all memory 0x00.
REQ-034 Reset values: o_byte_ready 0, o_fetch_valid 0, o_fetch_data 0x00, o_cpu_run 0, o_load_done 0, o_err 0.
REQ-035 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation; no partial completion pulse after release.

Verification
REQ-036 Load len 5, bytes 0x57,0x51,0x21,0x31,0x41 back-to-back -> ready high 5 cycles, o_load_done 1 pulse, o_cpu_run 1; fetch addr 2 -> next cycle valid 1, data 0x21.
REQ-037 Load len 3 with valid toggling 1,0,1,0,1 (bytes 0xA1,0xB2,0xC3 on valid cycles) -> only 3 writes; fetch 0..2 returns 0xA1,0xB2,0xC3; addr 3 returns 0x00.
REQ-038 i_load_start with len 0, then len 17 -> two o_err pulses, stay IDLE, o_byte_ready 0; fetch req -> o_fetch_valid 0.
REQ-039 Load len 16, bytes 0x10..0x1F -> done after 16th transfer; fetch addr 15 -> 0x1F; addr 0 -> 0x10 (no wrap overwrite).
REQ-040 Reset after 3 of 5 bytes -> all outputs 0; reload len 1 byte 0x99 -> fetch addr 0 = 0x99, addr 1 = 0x00.
REQ-041 In RUN, i_halt and i_load_start (len 2) same cycle -> LOAD entered, o_cpu_run 0 next edge, o_byte_ready 1.
